// File: rtl/compliment2_pkg.sv
// Shared types for the serial two's-complement unit: operating modes,
// controller states and the chunk-counter width helper.
package compliment2_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Counter width for n chunks; a single-chunk operand still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/compliment2_digit.sv
// One D-bit slice of the serial negator: optionally inverts the chunk and
// adds the incoming carry. Purely combinational.
module compliment2_digit #(
   parameter int D = 2
) (
   input  logic [D-1:0] x,
   input  logic         neg,
   input  logic         cin,
   output logic [D-1:0] s,
   output logic         cout
);

   logic [D:0] sum;

   // conditional inversion plus carry-in, carry-out kept in the top bit
   always_comb begin
      sum = {1'b0, (neg ? ~x : x)} + {{D{1'b0}}, cin};
   end

   assign s    = sum[D-1:0];
   assign cout = sum[D];

endmodule

// File: rtl/compliment2_serial.sv
// Multi-cycle two's-complement unit (pass / negate / abs), D bits per clock.
// Optional build macro COMPLIMENT2_SAT_EN: the most-negative operand under
// negate/abs saturates to the largest positive value instead of wrapping.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for an operand; accepts on in_valid
// ST_BUSY | one chunk per clock, LSB chunk first, carry held in carry_q
// ST_DONE | result presented on out_data/out_ovf until out_ready
import compliment2_pkg::*;

module compliment2_serial #(
   parameter int W = 10,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [1:0]   in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_ovf
);

   localparam int N  = W / D;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST     = CW'(N - 1);
   localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef COMPLIMENT2_SAT_EN
   localparam logic [W-1:0]  MOST_POS = {1'b0, {(W-1){1'b1}}};
`endif

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  shift_q, shift_d;
   logic          neg_q, neg_d;
   logic          ovf_q, ovf_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          out_ovf_q, out_ovf_d;

   logic          neg_in;
   logic [D-1:0]  dig_s;
   logic          dig_cout;

   // effective invert for the operand currently presented
   always_comb begin
      neg_in = 1'b0;
      case (mode_e'(in_mode))
         MODE_NEG: neg_in = 1'b1;
         MODE_ABS: neg_in = in_data[W-1];
         default:  neg_in = 1'b0;
      endcase
   end

   compliment2_digit #(.D(D)) u_digit (
      .x    (shift_q[D-1:0]),
      .neg  (neg_q),
      .cin  (carry_q),
      .s    (dig_s),
      .cout (dig_cout)
   );

   // next-state, datapath shifting and result capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      neg_d      = neg_q;
      ovf_d      = ovf_q;
      carry_d    = carry_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               shift_d = in_data;
               neg_d   = neg_in;
               ovf_d   = neg_in & (in_data == MOST_NEG);
               carry_d = neg_in;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // operand bits leave at the bottom, result chunks enter at the top
            shift_d = W'({dig_s, shift_q} >> D);
            carry_d = dig_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d    = ST_DONE;
               out_data_d = shift_d;
               out_ovf_d  = ovf_q;
`ifdef COMPLIMENT2_SAT_EN
               if (ovf_q) begin
                  out_data_d = MOST_POS;
               end
`endif
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         neg_q      <= 1'b0;
         ovf_q      <= 1'b0;
         carry_q    <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         neg_q      <= neg_d;
         ovf_q      <= ovf_d;
         carry_q    <= carry_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_compliment2_serial.sv
// Bench for compliment2_serial: a W=10/D=2 instance and a W=9/D=3 instance,
// directed cases plus random operations against an arithmetic reference.
module tb_compliment2_serial;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_ovf;
   logic [9:0] a_in_data = '0, a_out_data;
   logic [1:0] a_in_mode = '0;

   logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_ovf;
   logic [8:0] b_in_data = '0, b_out_data;
   logic [1:0] b_in_mode = '0;

   int checks   = 0;
   int failures = 0;

   logic        sel = 1'b0;
   logic [31:0] cur_out_data;
   logic        cur_out_valid, cur_in_ready, cur_out_ovf;

   always #5 clk = ~clk;

   compliment2_serial #(.W(10), .D(2)) u10 (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf)
   );

   compliment2_serial #(.W(9), .D(3)) u9 (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
   );

   always_comb begin
      cur_out_data  = sel ? {23'b0, b_out_data} : {22'b0, a_out_data};
      cur_out_valid = sel ? b_out_valid : a_out_valid;
      cur_in_ready  = sel ? b_in_ready  : a_in_ready;
      cur_out_ovf   = sel ? b_out_ovf   : a_out_ovf;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain modular arithmetic on the selected width.
   function automatic void model(input logic [31:0] data, input logic [1:0] mode,
                                 output logic [31:0] res, output logic ovf);
      longint m, v;
      bit neg;
      m   = 64'd1 << (sel ? 9 : 10);
      v   = longint'(data) % m;
      neg = (mode == 2'b01) || (mode == 2'b10 && v >= m / 2);
      res = 32'(neg ? (m - v) % m : v);
      ovf = neg && (v == m / 2);
`ifdef COMPLIMENT2_SAT_EN
      if (ovf) res = 32'(m / 2 - 1);
`endif
   endfunction

   task automatic drive(input logic valid, input logic [31:0] data, input logic [1:0] mode);
      a_in_data  = data[9:0];
      b_in_data  = data[8:0];
      a_in_mode  = mode;
      b_in_mode  = mode;
      a_in_valid = !sel && valid;
      b_in_valid = sel && valid;
   endtask

   task automatic set_out_ready(input logic v);
      if (sel) b_out_ready = v;
      else     a_out_ready = v;
   endtask

   // Present an operand; returns #1 after the accepting edge.
   task automatic send(input logic [31:0] data, input logic [1:0] mode);
      int k = 0;
      drive(1'b1, data, mode);
      while (!cur_in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("accept_ready", {31'b0, cur_in_ready}, 32'd1);
      @(posedge clk); #1;
      drive(1'b0, data, mode);
      check("busy_not_ready", {31'b0, cur_in_ready}, 32'd0);
   endtask

   task automatic wait_done(input logic [31:0] exp_data, input logic exp_ovf);
      int k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!cur_out_valid && k < 30);
      check("latency", 32'(k), sel ? 32'd3 : 32'd5);
      check("out_data", cur_out_data, exp_data);
      check("out_ovf", {31'b0, cur_out_ovf}, {31'b0, exp_ovf});
      check("done_not_ready", {31'b0, cur_in_ready}, 32'd0);
   endtask

   task automatic consume(input logic [31:0] exp_data);
      set_out_ready(1'b1);
      @(posedge clk); #1;
      set_out_ready(1'b0);
      check("consumed_valid", {31'b0, cur_out_valid}, 32'd0);
      check("consumed_ready", {31'b0, cur_in_ready}, 32'd1);
      check("held_after_hs", cur_out_data, exp_data);
   endtask

   task automatic run_op(input logic [31:0] data, input logic [1:0] mode, input int bp);
      logic [31:0] er;
      logic        eo;
      model(data, mode, er, eo);
      send(data, mode);
      wait_done(er, eo);
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {31'b0, cur_out_valid}, 32'd1);
         check("bp_data", cur_out_data, er);
      end
      consume(er);
   endtask

   initial begin
      logic [31:0] er;
      logic        eo;
      logic [31:0] rd;

      // reset state
      @(posedge clk); #1;
      check("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
      check("rst_out_data", {22'b0, a_out_data}, 32'd0);
      check("rst_out_ovf", {31'b0, a_out_ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed W=10 cases with constant expectations
      sel = 1'b0;
      send(32'd1, 2'b01);     wait_done(32'h3FF, 1'b0); consume(32'h3FF);
      send(32'h3F6, 2'b10);   wait_done(32'd10, 1'b0);  consume(32'd10);
      send(32'd7, 2'b10);     wait_done(32'd7, 1'b0);   consume(32'd7);
      send(32'd0, 2'b01);     wait_done(32'd0, 1'b0);   consume(32'd0);
`ifdef COMPLIMENT2_SAT_EN
      send(32'h200, 2'b01);   wait_done(32'h1FF, 1'b1); consume(32'h1FF);
      send(32'h200, 2'b10);   wait_done(32'h1FF, 1'b1); consume(32'h1FF);
`else
      send(32'h200, 2'b01);   wait_done(32'h200, 1'b1); consume(32'h200);
      send(32'h200, 2'b10);   wait_done(32'h200, 1'b1); consume(32'h200);
`endif

      // backpressure with a competing operand held on the input
      send(32'd9, 2'b01);
      wait_done(32'h3F7, 1'b0);
      drive(1'b1, 32'd5, 2'b01);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp3_valid", {31'b0, a_out_valid}, 32'd1);
         check("bp3_ready", {31'b0, a_in_ready}, 32'd0);
         check("bp3_data", {22'b0, a_out_data}, 32'h3F7);
      end
      set_out_ready(1'b1);
      @(posedge clk); #1;
      set_out_ready(1'b0);
      check("bp_consumed", {31'b0, a_out_valid}, 32'd0);
      check("bp_idle_ready", {31'b0, a_in_ready}, 32'd1);
      check("bp_old_data", {22'b0, a_out_data}, 32'h3F7);
      @(posedge clk); #1;
      drive(1'b0, 32'd5, 2'b01);
      check("bp_next_accepted", {31'b0, a_in_ready}, 32'd0);
      wait_done(32'h3FB, 1'b0);
      consume(32'h3FB);

      // reset during the third busy cycle
      send(32'd1, 2'b01);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, a_out_valid}, 32'd0);
      check("midrst_ready", {31'b0, a_in_ready}, 32'd1);
      @(posedge clk); #1;
      check("midrst_hold_valid", {31'b0, a_out_valid}, 32'd0);
      check("midrst_hold_ready", {31'b0, a_in_ready}, 32'd1);
      check("midrst_data", {22'b0, a_out_data}, 32'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      send(32'd3, 2'b01);     wait_done(32'h3FD, 1'b0); consume(32'h3FD);

      // random W=10 operations, occasionally the most-negative operand
      for (int i = 0; i < 24; i++) begin
         rd = (i % 6 == 5) ? 32'h200 : $urandom;
         run_op(rd, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      // W=9, D=3 instance
      sel = 1'b1;
      send(32'h1A5, 2'b00);   wait_done(32'h1A5, 1'b0); consume(32'h1A5);
      send(32'h100, 2'b11);   wait_done(32'h100, 1'b0); consume(32'h100);
      model(32'h100, 2'b01, er, eo);
      send(32'h100, 2'b01);   wait_done(er, eo);        consume(er);
      for (int i = 0; i < 12; i++) begin
         run_op($urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/compliment2_serial.md
# compliment2_serial

Parametrised, multi-cycle two's-complement unit for the FloatToNum path. It generalises the fixed 9/10-bit combinational negators to any width and adds pass, negate and absolute-value modes. Operands are processed D bits per clock through a registered carry, with valid/ready handshakes on both sides and an overflow flag for the most-negative operand. It sits between mantissa/exponent alignment and the decimal conversion stage.

## Interface
- W, 10: operand/result width in bits; W ≥ 2.
- D, 2: bits processed per cycle; W % D == 0; N = W/D chunk cycles.
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operand presented.
- in_ready  out  1: unit can accept.
- in_data  in  W: operand, two's complement.
- in_mode  in  2: 00 pass, 01 negate, 10 abs, 11 pass (reserved).
- out_valid  out  1: result held.
- out_ready  in  1: consumer accepts.
- out_data  out  W: result.
- out_ovf  out  1: negate/abs applied to 1 followed by W−1 zeros.

## Operation
- Effective invert `neg` = (mode==01) | (mode==10 & in_data[W−1]); latched with the operand at acceptance.
- Chunk i (bits i·D+D−1 : i·D) = (neg ? ~x_i : x_i) + c; the chunk carry-out becomes the next c.
- Initial c = neg. The final carry-out is discarded, so negate 0 gives 0.
- States:
  - IDLE: in_ready=1. If in_valid, latch operand, mode, neg and ovf, set chunk counter to 0, go to BUSY.
  - BUSY: one chunk per cycle, LSB chunk first; result shift register filled. After chunk N−1, go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE.
- ovf = neg & (in_data == {1,0…0}), computed at acceptance.
- in_ready=0 in BUSY and DONE. No overlap; in_valid is ignored outside IDLE.
- out_data and out_ovf stay stable throughout DONE and keep their values after the handshake until the next result.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0.
  - out_data=0, out_ovf=0, carry=0, counter=0.
- Reset takes effect immediately, including mid-BUSY or mid-DONE. The in-flight operation is lost and no partial result is flagged valid.
- Accept at edge 0. Chunk i is computed at edge i+1. out_valid is high from edge N.
- With out_ready held high, the result is consumed at edge N+1. Next acceptance is possible at edge N+2, giving a throughput of one operation per N+2 cycles.
- Backpressure: DONE holds indefinitely and the output does not change.

## Configuration
- COMPLIMENT2_SAT_EN defined: when ovf=1, out_data = {0,1…1} (largest positive value).
- Undefined: when ovf=1, out_data wraps to {1,0…0}.
- out_ovf is asserted identically in both builds.

## Structure
- Package compliment2_pkg:
  - mode enum (MODE_PASS, MODE_NEG, MODE_ABS, MODE_RSVD).
  - state enum (ST_IDLE, ST_BUSY, ST_DONE).
  - width helper for the counter, $clog2(N).
- Sub-module compliment2_digit: combinational D-bit slice with inputs x, neg, cin and outputs s, cout. It is instantiated once and reused each cycle.
- Top level holds the FSM, counter, operand/result shift registers, carry register and saturation mux.

## Test plan
- W=10, D=2, negate 10'd1 → out_data 10'h3FF, out_ovf 0, out_valid first high 5 cycles after acceptance.
- W=10, D=2:
  - abs 10'h3F6 → 10'd10.
  - abs 10'd7 → 10'd7.
  - negate 10'd0 → 10'd0, out_ovf 0.
- W=10, D=2, negate 10'h200:
  - Without macro → 10'h200, out_ovf 1.
  - With COMPLIMENT2_SAT_EN → 10'h1FF, out_ovf 1.
  - Same results for abs 10'h200.
- Backpressure:
  - Hold out_ready low 3 cycles in DONE → out_data stable and in_ready 0.
  - A concurrent in_valid with 10'd5 is not accepted.
  - Result consumed on the first out_ready high; 10'd5 accepted the following cycle.
- Reset mid-operation: assert rst during the 3rd BUSY cycle → out_valid 0 and in_ready 1 while rst is high. After release, negate 10'd3 → 10'h3FD.
- W=9, D=3, pass 9'h1A5 → 9'h1A5 after 3 cycles. Mode 11 with 9'h100 → 9'h100, out_ovf 0.
